// File: rtl/cosim_commit_queue_if.sv
// Retire-trace bus between the core, the commit queue and the co-sim sink.
// master drives retire events and out_ready; slave is the queue side.
interface cosim_commit_queue_if #(
    parameter int COMMIT_WIDTH = 2,
    parameter int OUT_WIDTH    = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int HARTID_LEN   = 1
);
    logic [HARTID_LEN-1:0]           hartid;
    logic [COMMIT_WIDTH-1:0]         in_valid;
    logic [XLEN*COMMIT_WIDTH-1:0]    in_pc;
    logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst;
    logic [XLEN*COMMIT_WIDTH-1:0]    in_wdata;
    logic [XLEN*COMMIT_WIDTH-1:0]    in_mstatus;
    logic [COMMIT_WIDTH-1:0]         in_check;
    logic                            in_int_xcpt;
    logic [XLEN-1:0]                 in_cause;
    logic                            in_ready;
    logic                            out_ready;
    logic [OUT_WIDTH-1:0]            out_valid;
    logic [HARTID_LEN-1:0]           out_hartid;
    logic [XLEN*OUT_WIDTH-1:0]       out_pc;
    logic [INST_BITS*OUT_WIDTH-1:0]  out_inst;
    logic [XLEN*OUT_WIDTH-1:0]       out_wdata;
    logic [XLEN*OUT_WIDTH-1:0]       out_mstatus;
    logic [OUT_WIDTH-1:0]            out_check;
    logic                            out_int_xcpt;
    logic [XLEN-1:0]                 out_cause;
    logic                            overflow;

    modport master (
        output hartid, in_valid, in_pc, in_inst, in_wdata,
        output in_mstatus, in_check, in_int_xcpt, in_cause,
        output out_ready,
        input  in_ready, out_valid, out_hartid, out_pc, out_inst,
        input  out_wdata, out_mstatus, out_check, out_int_xcpt,
        input  out_cause, overflow
    );

    modport slave (
        input  hartid, in_valid, in_pc, in_inst, in_wdata,
        input  in_mstatus, in_check, in_int_xcpt, in_cause,
        input  out_ready,
        output in_ready, out_valid, out_hartid, out_pc, out_inst,
        output out_wdata, out_mstatus, out_check, out_int_xcpt,
        output out_cause, overflow
    );
endinterface

// File: rtl/cosim_commit_queue.sv
// Program-ordered commit/trap FIFO feeding the Dromajo co-sim step sink.
// Define COSIM_QUEUE_STATS_EN to add drain/occupancy statistics outputs.
module cosim_commit_queue #(
    parameter int COMMIT_WIDTH = 2,
    parameter int OUT_WIDTH    = 2,
    parameter int XLEN         = 64,
    parameter int INST_BITS    = 32,
    parameter int HARTID_LEN   = 1,
    parameter int DEPTH        = 16
) (
    input  logic clock,
    input  logic reset,
    cosim_commit_queue_if.slave bus
`ifdef COSIM_QUEUE_STATS_EN
    ,
    output logic [63:0]              stat_commits,
    output logic [31:0]              stat_traps,
    output logic [$clog2(DEPTH):0]   stat_max_occ
`endif
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int PW   = $clog2(COMMIT_WIDTH + 2);
    localparam int KW   = $clog2(OUT_WIDTH + 1);

    typedef struct packed {
        logic                 trap;
        logic [XLEN-1:0]      pc;
        logic [INST_BITS-1:0] inst;
        logic [XLEN-1:0]      wdata;
        logic [XLEN-1:0]      mstatus;
        logic                 check;
    } entry_t;

    entry_t r_mem [DEPTH];

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CNTW-1:0] r_cnt;
    logic            r_ovf;

    logic [OUT_WIDTH-1:0]           r_out_valid;
    logic [HARTID_LEN-1:0]          r_out_hartid;
    logic [XLEN*OUT_WIDTH-1:0]      r_out_pc;
    logic [INST_BITS*OUT_WIDTH-1:0] r_out_inst;
    logic [XLEN*OUT_WIDTH-1:0]      r_out_wdata;
    logic [XLEN*OUT_WIDTH-1:0]      r_out_mstatus;
    logic [OUT_WIDTH-1:0]           r_out_check;
    logic                           r_out_xcpt;
    logic [XLEN-1:0]                r_out_cause;

    logic            w_event;
    logic            w_ready;
    logic            w_push;
    logic [PW-1:0]   w_off [COMMIT_WIDTH];
    logic [PW-1:0]   w_ncom;
    logic [PW-1:0]   w_nwr;
    logic [KW-1:0]   w_k;
    logic            w_trap;
    logic [CNTW-1:0] w_npop;
    logic [CNTW-1:0] w_cnt_nxt;

    assign w_event = (|bus.in_valid) | bus.in_int_xcpt;
    // Readiness ignores the concurrent drain so a full event always fits.
    assign w_ready = r_cnt <= CNTW'(DEPTH - COMMIT_WIDTH - 1);
    assign w_push  = w_event & w_ready;

    always_comb begin
        logic [PW-1:0] v_acc;
        v_acc = '0;
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            w_off[l] = v_acc;
            v_acc    = v_acc + PW'(bus.in_valid[l]);
        end
        w_ncom = v_acc;
        w_nwr  = v_acc + PW'(bus.in_int_xcpt);
    end

    always_comb begin
        int   v_k;
        logic v_stop;
        v_k    = 0;
        v_stop = 1'b0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (!v_stop && CNTW'(i) < r_cnt
                && !r_mem[r_rptr + AW'(i)].trap)
                v_k = v_k + 1;
            else
                v_stop = 1'b1;
        end
        w_k    = KW'(v_k);
        w_trap = (CNTW'(v_k) < r_cnt) && r_mem[r_rptr + AW'(v_k)].trap;
    end

    assign w_npop    = bus.out_ready ? CNTW'(w_k) + CNTW'(w_trap) : '0;
    assign w_cnt_nxt = r_cnt + (w_push ? CNTW'(w_nwr) : '0) - w_npop;

    always_ff @(posedge clock) begin
        if (w_push) begin
            for (int l = 0; l < COMMIT_WIDTH; l++) begin
                if (bus.in_valid[l]) begin
                    r_mem[r_wptr + AW'(w_off[l])] <= '{
                        trap:    1'b0,
                        pc:      bus.in_pc[l*XLEN +: XLEN],
                        inst:    bus.in_inst[l*INST_BITS +: INST_BITS],
                        wdata:   bus.in_wdata[l*XLEN +: XLEN],
                        mstatus: bus.in_mstatus[l*XLEN +: XLEN],
                        check:   bus.in_check[l]
                    };
                end
            end
            if (bus.in_int_xcpt) begin
                r_mem[r_wptr + AW'(w_ncom)] <= '{
                    trap:    1'b1,
                    pc:      '0,
                    inst:    '0,
                    wdata:   bus.in_cause,
                    mstatus: '0,
                    check:   1'b0
                };
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_out_valid   <= '0;
            r_out_hartid  <= '0;
            r_out_pc      <= '0;
            r_out_inst    <= '0;
            r_out_wdata   <= '0;
            r_out_mstatus <= '0;
            r_out_check   <= '0;
            r_out_xcpt    <= 1'b0;
            r_out_cause   <= '0;
        end else begin
            r_out_hartid <= bus.hartid;
            r_cnt        <= w_cnt_nxt;
            if (w_event && !w_ready)
                r_ovf <= 1'b1;
            if (w_push)
                r_wptr <= r_wptr + AW'(w_nwr);
            r_out_valid <= '0;
            r_out_xcpt  <= 1'b0;
            if (bus.out_ready) begin
                r_rptr <= r_rptr + AW'(w_npop);
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    if (KW'(i) < w_k) begin
                        r_out_valid[i] <= 1'b1;
                        r_out_pc[i*XLEN +: XLEN] <=
                            r_mem[r_rptr + AW'(i)].pc;
                        r_out_inst[i*INST_BITS +: INST_BITS] <=
                            r_mem[r_rptr + AW'(i)].inst;
                        r_out_wdata[i*XLEN +: XLEN] <=
                            r_mem[r_rptr + AW'(i)].wdata;
                        r_out_mstatus[i*XLEN +: XLEN] <=
                            r_mem[r_rptr + AW'(i)].mstatus;
                        r_out_check[i] <= r_mem[r_rptr + AW'(i)].check;
                    end
                end
                if (w_trap) begin
                    r_out_xcpt  <= 1'b1;
                    r_out_cause <= r_mem[r_rptr + AW'(w_k)].wdata;
                end
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_hartid   = r_out_hartid;
    assign bus.out_pc       = r_out_pc;
    assign bus.out_inst     = r_out_inst;
    assign bus.out_wdata    = r_out_wdata;
    assign bus.out_mstatus  = r_out_mstatus;
    assign bus.out_check    = r_out_check;
    assign bus.out_int_xcpt = r_out_xcpt;
    assign bus.out_cause    = r_out_cause;
    assign bus.overflow     = r_ovf;

`ifdef COSIM_QUEUE_STATS_EN
    logic [63:0]     r_st_commits;
    logic [31:0]     r_st_traps;
    logic [CNTW-1:0] r_st_max;
    logic [64:0]     w_st_sum;

    assign w_st_sum = 65'(r_st_commits) + 65'(w_k);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_st_commits <= '0;
            r_st_traps   <= '0;
            r_st_max     <= '0;
        end else begin
            if (bus.out_ready) begin
                r_st_commits <= w_st_sum[64] ? '1 : w_st_sum[63:0];
                if (w_trap && r_st_traps != '1)
                    r_st_traps <= r_st_traps + 32'd1;
            end
            if (w_cnt_nxt > r_st_max)
                r_st_max <= w_cnt_nxt;
        end
    end

    assign stat_commits = r_st_commits;
    assign stat_traps   = r_st_traps;
    assign stat_max_occ = r_st_max;
`endif
endmodule

// File: tb/tb_cosim_commit_queue.sv
// Bench for cosim_commit_queue: directed vectors plus random traffic
// checked against a queue-based model, on OUT_WIDTH=2 and OUT_WIDTH=1 copies.
module tb_cosim_commit_queue;
    localparam int CW = 2;
    localparam int XL = 64;
    localparam int IB = 32;
    localparam int HL = 1;
    localparam int D  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cosim_commit_queue_if #(.COMMIT_WIDTH(CW), .OUT_WIDTH(2), .XLEN(XL),
        .INST_BITS(IB), .HARTID_LEN(HL)) ifa ();
    cosim_commit_queue_if #(.COMMIT_WIDTH(CW), .OUT_WIDTH(1), .XLEN(XL),
        .INST_BITS(IB), .HARTID_LEN(HL)) ifb ();

    // Second copy sees exactly the same input stream.
    assign ifb.hartid      = ifa.hartid;
    assign ifb.in_valid    = ifa.in_valid;
    assign ifb.in_pc       = ifa.in_pc;
    assign ifb.in_inst     = ifa.in_inst;
    assign ifb.in_wdata    = ifa.in_wdata;
    assign ifb.in_mstatus  = ifa.in_mstatus;
    assign ifb.in_check    = ifa.in_check;
    assign ifb.in_int_xcpt = ifa.in_int_xcpt;
    assign ifb.in_cause    = ifa.in_cause;
    assign ifb.out_ready   = ifa.out_ready;

    cosim_commit_queue #(.COMMIT_WIDTH(CW), .OUT_WIDTH(2), .XLEN(XL),
        .INST_BITS(IB), .HARTID_LEN(HL), .DEPTH(D))
        u_a (.clock(clock), .reset(reset), .bus(ifa));
    cosim_commit_queue #(.COMMIT_WIDTH(CW), .OUT_WIDTH(1), .XLEN(XL),
        .INST_BITS(IB), .HARTID_LEN(HL), .DEPTH(D))
        u_b (.clock(clock), .reset(reset), .bus(ifb));

    typedef struct {
        bit        trap;
        bit [63:0] pc;
        bit [31:0] inst;
        bit [63:0] wdata;
        bit [63:0] mst;
        bit        chk;
    } ent_t;

    ent_t      q0[$];
    ent_t      q1[$];
    bit [1:0]  e_valid [2];
    bit [63:0] e_pc    [2][2];
    bit [31:0] e_inst  [2][2];
    bit [63:0] e_wd    [2][2];
    bit [63:0] e_ms    [2][2];
    bit        e_chk   [2][2];
    bit        e_x     [2];
    bit [63:0] e_cause [2];
    bit        e_ovf   [2];
    bit        e_hart;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step(input int m, input int ow);
        ent_t qq[$];
        ent_t e;
        int   k;
        bit   rdy;
        if (m == 0) qq = q0; else qq = q1;
        if (reset === 1'b0) begin
            qq.delete();
            e_valid[m] = '0;
            e_x[m]     = 1'b0;
            e_cause[m] = '0;
            e_ovf[m]   = 1'b0;
            for (int l = 0; l < 2; l++) begin
                e_pc[m][l] = '0; e_inst[m][l] = '0; e_wd[m][l] = '0;
                e_ms[m][l] = '0; e_chk[m][l] = 1'b0;
            end
        end else begin
            rdy = qq.size() <= D - CW - 1;
            e_valid[m] = '0;
            e_x[m]     = 1'b0;
            if (ifa.out_ready) begin
                k = 0;
                while (k < ow && k < qq.size() && !qq[k].trap) k++;
                e_valid[m] = 2'((1 << k) - 1);
                for (int l = 0; l < k; l++) begin
                    e = qq.pop_front();
                    e_pc[m][l] = e.pc; e_inst[m][l] = e.inst;
                    e_wd[m][l] = e.wdata; e_ms[m][l] = e.mst;
                    e_chk[m][l] = e.chk;
                end
                if (qq.size() > 0 && qq[0].trap) begin
                    e = qq.pop_front();
                    e_x[m]     = 1'b1;
                    e_cause[m] = e.wdata;
                end
            end
            if (|ifa.in_valid || ifa.in_int_xcpt) begin
                if (rdy) begin
                    for (int l = 0; l < CW; l++) begin
                        if (ifa.in_valid[l]) begin
                            e.trap  = 1'b0;
                            e.pc    = ifa.in_pc[l*64 +: 64];
                            e.inst  = ifa.in_inst[l*32 +: 32];
                            e.wdata = ifa.in_wdata[l*64 +: 64];
                            e.mst   = ifa.in_mstatus[l*64 +: 64];
                            e.chk   = ifa.in_check[l];
                            qq.push_back(e);
                        end
                    end
                    if (ifa.in_int_xcpt) begin
                        e = '{1'b1, 64'd0, 32'd0, ifa.in_cause, 64'd0, 1'b0};
                        qq.push_back(e);
                    end
                end else begin
                    e_ovf[m] = 1'b1;
                end
            end
        end
        if (m == 0) q0 = qq; else q1 = qq;
    endtask

    task automatic compare(input int m, input int ow, input logic [1:0] v,
        input logic [127:0] pc, input logic [63:0] inst,
        input logic [127:0] wd, input logic [127:0] ms, input logic [1:0] ck,
        input logic x, input logic [63:0] cause, input logic ovf,
        input logic rdy, input logic hart, input int qsz);
        string p;
        p = (m == 0) ? "a." : "b.";
        chk({p, "out_valid"}, v, e_valid[m]);
        chk({p, "out_int_xcpt"}, x, e_x[m]);
        chk({p, "out_cause"}, cause, e_cause[m]);
        chk({p, "overflow"}, ovf, e_ovf[m]);
        chk({p, "in_ready"}, rdy, qsz <= D - CW - 1);
        chk({p, "out_hartid"}, hart, e_hart);
        for (int l = 0; l < ow; l++) begin
            chk($sformatf("%sout_pc%0d", p, l), pc[l*64 +: 64], e_pc[m][l]);
            chk($sformatf("%sout_inst%0d", p, l), inst[l*32 +: 32],
                e_inst[m][l]);
            chk($sformatf("%sout_wdata%0d", p, l), wd[l*64 +: 64],
                e_wd[m][l]);
            chk($sformatf("%sout_mstatus%0d", p, l), ms[l*64 +: 64],
                e_ms[m][l]);
            chk($sformatf("%sout_check%0d", p, l), ck[l], e_chk[m][l]);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        step(0, 2);
        step(1, 1);
        e_hart = (reset === 1'b0) ? 1'b0 : ifa.hartid;
        #1;
        compare(0, 2, ifa.out_valid, ifa.out_pc, ifa.out_inst,
            ifa.out_wdata, ifa.out_mstatus, ifa.out_check, ifa.out_int_xcpt,
            ifa.out_cause, ifa.overflow, ifa.in_ready, ifa.out_hartid,
            q0.size());
        compare(1, 1, 2'(ifb.out_valid), 128'(ifb.out_pc),
            64'(ifb.out_inst), 128'(ifb.out_wdata), 128'(ifb.out_mstatus),
            2'(ifb.out_check), ifb.out_int_xcpt, ifb.out_cause,
            ifb.overflow, ifb.in_ready, ifb.out_hartid, q1.size());
        @(negedge clock);
    endtask

    task automatic set_in(input logic [1:0] v, input logic [63:0] p0,
        input logic [63:0] p1, input logic x, input logic [63:0] c);
        ifa.in_valid    = v;
        ifa.in_pc       = {p1, p0};
        ifa.in_inst     = {p1[31:0] ^ 32'h13, p0[31:0] ^ 32'h13};
        ifa.in_wdata    = {~p1, ~p0};
        ifa.in_mstatus  = {p1 << 1, p0 << 1};
        ifa.in_check    = {p1[2], p0[2]};
        ifa.in_int_xcpt = x;
        ifa.in_cause    = c;
    endtask

    task automatic idle();
        set_in(2'b00, 64'd0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        bit [1:0]  v;
        bit [63:0] p0;
        bit [63:0] p1;
        bit        x;
        bit [63:0] c;
        bit [1:0]  ev;
        bit [63:0] ep0;
        bit [63:0] ep1;
        bit        ex;
    } vec_t;

    vec_t tv[5];

    initial begin
        int lanes;
        tv[0] = '{2'b10, 64'h0, 64'h8000_0004, 1'b0, 64'h0,
                  2'b01, 64'h8000_0004, 64'h0, 1'b0};
        tv[1] = '{2'b11, 64'h100, 64'h104, 1'b1, 64'h8000_0000_0000_0007,
                  2'b11, 64'h100, 64'h104, 1'b1};
        tv[2] = '{2'b01, 64'h200, 64'h9999, 1'b0, 64'h0,
                  2'b01, 64'h200, 64'h0, 1'b0};
        tv[3] = '{2'b00, 64'h0, 64'h0, 1'b1, 64'h2,
                  2'b00, 64'h0, 64'h0, 1'b1};
        tv[4] = '{2'b11, 64'h300, 64'h304, 1'b0, 64'h0,
                  2'b11, 64'h300, 64'h304, 1'b0};

        ifa.hartid    = 1'b1;
        ifa.out_ready = 1'b1;
        idle();
        do_reset();
        cycle();
        chk("reset in_ready", ifa.in_ready, 1'b1);
        chk("reset out_valid", ifa.out_valid, 2'b00);
        chk("reset overflow", ifa.overflow, 1'b0);
        chk("reset out_pc", ifa.out_pc, 128'd0);

        // Directed single-event vectors
        foreach (tv[i]) begin
            set_in(tv[i].v, tv[i].p0, tv[i].p1, tv[i].x, tv[i].c);
            cycle();
            idle();
            cycle();
            chk($sformatf("vec%0d valid", i), ifa.out_valid, tv[i].ev);
            if (tv[i].ev[0])
                chk($sformatf("vec%0d pc0", i), ifa.out_pc[63:0], tv[i].ep0);
            if (tv[i].ev[1])
                chk($sformatf("vec%0d pc1", i), ifa.out_pc[127:64],
                    tv[i].ep1);
            chk($sformatf("vec%0d xcpt", i), ifa.out_int_xcpt, tv[i].ex);
            if (tv[i].ex)
                chk($sformatf("vec%0d cause", i), ifa.out_cause, tv[i].c);
            cycle();
            chk($sformatf("vec%0d pulse", i), ifa.out_valid, 2'b00);
            cycle();
        end

        // Throttled queue drains in order, two lanes per pulse
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(2'b11, 64'(i * 8), 64'(i * 8 + 4), 1'b0, 64'd0);
            cycle();
        end
        idle();
        cycle();
        chk("t3 held", ifa.out_valid, 2'b00);
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("t3 valid%0d", i), ifa.out_valid, 2'b11);
            chk($sformatf("t3 pcs%0d", i), ifa.out_pc,
                {64'(i * 8 + 4), 64'(i * 8)});
        end
        cycle();
        chk("t3 done", ifa.out_valid, 2'b00);
        repeat (8) cycle();

        // Fill to 14, then a further event is dropped
        do_reset();
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_in(2'b11, 64'h1000 + 64'(i * 8), 64'h1004 + 64'(i * 8),
                   1'b0, 64'd0);
            cycle();
        end
        idle();
        cycle();
        chk("t4 in_ready", ifa.in_ready, 1'b0);
        set_in(2'b01, 64'hdead, 64'd0, 1'b0, 64'd0);
        cycle();
        idle();
        chk("t4 overflow", ifa.overflow, 1'b1);
        ifa.out_ready = 1'b1;
        lanes = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            lanes += int'(ifa.out_valid[0]) + int'(ifa.out_valid[1]);
        end
        chk("t4 occupancy", 128'(lanes), 128'd14);
        repeat (8) cycle();

        // Commit, trap, commit with a single output lane
        do_reset();
        ifa.out_ready = 1'b0;
        set_in(2'b01, 64'h200, 64'd0, 1'b1, 64'h5);
        cycle();
        set_in(2'b01, 64'h300, 64'd0, 1'b0, 64'd0);
        cycle();
        idle();
        ifa.out_ready = 1'b1;
        cycle();
        chk("t5 valid A", ifb.out_valid, 1'b1);
        chk("t5 pc A", ifb.out_pc, 64'h200);
        chk("t5 trap", ifb.out_int_xcpt, 1'b1);
        chk("t5 cause", ifb.out_cause, 64'h5);
        cycle();
        chk("t5 valid B", ifb.out_valid, 1'b1);
        chk("t5 pc B", ifb.out_pc, 64'h300);
        chk("t5 no trap", ifb.out_int_xcpt, 1'b0);
        repeat (2) cycle();

        // Reset while draining
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, 64'h4000 + 64'(i * 8), 64'h4004 + 64'(i * 8),
                   1'b0, 64'd0);
            cycle();
        end
        idle();
        ifa.out_ready = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("t6 valid", ifa.out_valid, 2'b00);
        chk("t6 in_ready", ifa.in_ready, 1'b1);
        chk("t6 b valid", ifb.out_valid, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("t6 stale%0d", i),
                {ifa.out_valid, ifa.out_int_xcpt}, 3'b000);
        end

        // Random traffic with throttle bursts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(2'($urandom_range(0, 3)), {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 5) == 0,
                   {$urandom, $urandom});
            if (i % 200 < 30)
                ifa.out_ready = 1'b0;
            else
                ifa.out_ready = $urandom_range(0, 3) != 0;
            cycle();
        end
        idle();
        ifa.out_ready = 1'b1;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
